// File: rtl/gpu_pkg.sv
// Shared GPU core types: scheduler core states, LSU handshake states, opcodes
// and the default LSU watchdog limit.
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

    localparam logic [3:0] OPCODE_LDR = 4'b0111;
    localparam logic [3:0] OPCODE_STR = 4'b1000;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_watchdog.sv
// Clear/increment counter that flags the cycle on which the increment would
// reach TERMINAL. Used by lsu to bound the WAITING state.
module lsu_watchdog #(
    parameter int unsigned TERMINAL = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int unsigned W = (TERMINAL < 2) ? 1 : $clog2(TERMINAL + 1);

    logic [W-1:0] count;

    assign expire = inc && (count == W'(TERMINAL - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lsu.sv
// Per-thread load/store unit driving the lsu_state_t memory handshake.
// Optional WAITING timeout with lsu_error reporting under `define LSU_TIMEOUT_EN.
module lsu
    import gpu_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    lsu_state_t           state, state_d;
    core_state_t          cs;
    logic                 op_read, op_read_d;
    logic                 rvalid_d, wvalid_d;
    logic [ADDR_BITS-1:0] raddr_d, waddr_d;
    logic [DATA_BITS-1:0] wdata_d, out_d;
    logic [ADDR_BITS-1:0] addr_ext;
    logic                 start;
    logic                 ready_hit;
    logic                 in_wait;
    logic                 expire;

    assign cs        = core_state_t'(core_state);
    assign lsu_state = state;
    assign in_wait   = (state == LSU_WAITING);
    // Only the ready matching the outstanding request type counts.
    assign ready_hit = op_read ? mem_read_ready : mem_write_ready;

    if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
        assign addr_ext = rs[ADDR_BITS-1:0];
    end else begin : g_addr_zext
        assign addr_ext = {{(ADDR_BITS - DATA_BITS){1'b0}}, rs};
    end

`ifdef LSU_TIMEOUT_EN
    logic error_q;

    lsu_watchdog #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == LSU_REQUESTING),
        .inc    (in_wait && !ready_hit),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (start) begin
            error_q <= 1'b0;
        end else if (in_wait && expire) begin
            error_q <= 1'b1;
        end
    end

    assign lsu_error = error_q;
`else
    assign expire    = 1'b0;
    assign lsu_error = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        op_read_d = op_read;
        rvalid_d  = mem_read_valid;
        wvalid_d  = mem_write_valid;
        raddr_d   = mem_read_address;
        waddr_d   = mem_write_address;
        wdata_d   = mem_write_data;
        out_d     = lsu_out;
        start     = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (enable && cs == REQUEST &&
                    (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                    start     = 1'b1;
                    op_read_d = decoded_mem_read_enable;
                    state_d   = LSU_REQUESTING;
                end
            end
            LSU_REQUESTING: begin
                if (op_read) begin
                    rvalid_d = 1'b1;
                    raddr_d  = addr_ext;
                end else begin
                    wvalid_d = 1'b1;
                    waddr_d  = addr_ext;
                    wdata_d  = rt;
                end
                state_d = LSU_WAITING;
            end
            LSU_WAITING: begin
                // Ready on the expiry edge takes priority over the timeout.
                if (ready_hit) begin
                    rvalid_d = 1'b0;
                    wvalid_d = 1'b0;
                    if (op_read) begin
                        out_d = mem_read_data;
                    end
                    state_d = LSU_DONE;
                end else if (expire) begin
                    rvalid_d = 1'b0;
                    wvalid_d = 1'b0;
                    state_d  = LSU_DONE;
                end
            end
            LSU_DONE: begin
                if (cs == UPDATE) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= LSU_IDLE;
            op_read           <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_write_valid   <= 1'b0;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
        end else begin
            state             <= state_d;
            op_read           <= op_read_d;
            mem_read_valid    <= rvalid_d;
            mem_write_valid   <= wvalid_d;
            mem_read_address  <= raddr_d;
            mem_write_address <= waddr_d;
            mem_write_data    <= wdata_d;
            lsu_out           <= out_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected requests are queued at issue and checked
// when the memory-side valid appears. Timeout scenarios need LSU_TIMEOUT_EN.
module tb_lsu;
    import gpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       rd_en, wr_en;
    logic [7:0] rs, rt;
    logic       mem_read_valid, mem_read_ready;
    logic [7:0] mem_read_address, mem_read_data;
    logic       mem_write_valid, mem_write_ready;
    logic [7:0] mem_write_address, mem_write_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    int checks = 0;
    int failures = 0;
    logic [7:0] model_out = 8'h00;

    typedef struct {
        bit         rd;
        logic [7:0] addr;
        logic [7:0] wdata;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0] st_req;
        logic       err_req;
        int         valid_cycles;
        bit         any_r;
        bit         any_w;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         stable;
        int         done_at;
        logic [1:0] st_done;
        logic [7:0] out_done;
        logic       err_done;
        logic [1:0] st_idle;
    } obs_t;

    always #5 clk = ~clk;

    lsu #(
        .DATA_BITS      (8),
        .ADDR_BITS      (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .rs                       (rs),
        .rt                       (rt),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .lsu_error                (lsu_error)
    );

    // Drives one transaction and records what the DUT did; negedge index 1 is
    // the cycle after the REQUEST edge. Wrong-type ready is held high on every
    // non-final wait cycle.
    task automatic do_txn(input bit rd, input bit wr, input logic [7:0] a,
                          input logic [7:0] d, input int delay,
                          input logic [7:0] rdata, input bit drop_en,
                          output obs_t o);
        int n;
        bit last;
        o = '{default: 0};
        o.stable = 1'b1;
        @(negedge clk);
        enable = 1'b1; core_state = REQUEST; rd_en = rd; wr_en = wr; rs = a; rt = d;
        @(negedge clk);
        n = 1;
        o.st_req = lsu_state;
        o.err_req = lsu_error;
        core_state = WAIT;
        if (drop_en) enable = 1'b0;
        while (!(mem_read_valid || mem_write_valid) && n < 4) begin
            @(negedge clk);
            n++;
        end
        o.addr  = mem_read_valid ? mem_read_address : mem_write_address;
        o.wdata = mem_write_data;
        while ((mem_read_valid || mem_write_valid) && o.valid_cycles < 300) begin
            o.valid_cycles++;
            o.any_r |= mem_read_valid;
            o.any_w |= mem_write_valid;
            if ((mem_read_valid ? mem_read_address : mem_write_address) !== o.addr ||
                (mem_write_valid && mem_write_data !== o.wdata))
                o.stable = 1'b0;
            last = (o.valid_cycles - 1 == delay);
            if (rd) begin
                mem_read_ready = last; mem_write_ready = !last;
            end else begin
                mem_write_ready = last; mem_read_ready = !last;
            end
            mem_read_data = last ? rdata : ~rdata;
            @(negedge clk);
            n++;
        end
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        o.done_at  = n;
        o.st_done  = lsu_state;
        o.out_done = lsu_out;
        o.err_done = lsu_error;
        core_state = UPDATE;
        @(negedge clk);
        o.st_idle = lsu_state;
        core_state = IDLE; rd_en = 1'b0; wr_en = 1'b0; enable = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (lsu_state !== LSU_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", lsu_state, LSU_IDLE); end
        checks++; if ({mem_read_valid, mem_write_valid} !== 2'b00) begin failures++; $display("FAIL reset_valids got=%b exp=00", {mem_read_valid, mem_write_valid}); end
        checks++; if ({mem_read_address, mem_write_address, mem_write_data} !== 24'h0) begin failures++; $display("FAIL reset_addr_data got=%h exp=0", {mem_read_address, mem_write_address, mem_write_data}); end
        checks++; if (lsu_out !== 8'h00) begin failures++; $display("FAIL reset_lsu_out got=%h exp=00", lsu_out); end
        checks++; if (lsu_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", lsu_error); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_immediate();
        obs_t o;
        exp_t e;
        sb.push_back('{rd: 1'b1, addr: 8'h12, wdata: 8'h00});
        do_txn(1'b1, 1'b0, 8'h12, 8'h00, 0, 8'hA5, 1'b0, o);
        model_out = 8'hA5;
        e = sb.pop_front();
        checks++; if (o.st_req !== LSU_REQUESTING) begin failures++; $display("FAIL load_req_state got=%0d exp=%0d", o.st_req, LSU_REQUESTING); end
        checks++; if (o.any_r !== e.rd || o.any_w !== 1'b0) begin failures++; $display("FAIL load_type got=r%0d w%0d exp=r1 w0", o.any_r, o.any_w); end
        checks++; if (o.addr !== e.addr) begin failures++; $display("FAIL load_addr got=%h exp=%h", o.addr, e.addr); end
        checks++; if (o.valid_cycles != 1) begin failures++; $display("FAIL load_valid_cycles got=%0d exp=1", o.valid_cycles); end
        checks++; if (o.done_at != 3 || o.st_done !== LSU_DONE) begin failures++; $display("FAIL load_done got=%0d@%0d exp=%0d@3", o.st_done, o.done_at, LSU_DONE); end
        checks++; if (o.out_done !== model_out) begin failures++; $display("FAIL load_out got=%h exp=%h", o.out_done, model_out); end
        checks++; if (o.err_done !== 1'b0) begin failures++; $display("FAIL load_error got=%b exp=0", o.err_done); end
        checks++; if (o.st_idle !== LSU_IDLE) begin failures++; $display("FAIL load_idle got=%0d exp=%0d", o.st_idle, LSU_IDLE); end
    endtask

    task automatic test_store_delayed();
        obs_t o;
        exp_t e;
        sb.push_back('{rd: 1'b0, addr: 8'h40, wdata: 8'h7E});
        do_txn(1'b0, 1'b1, 8'h40, 8'h7E, 5, 8'h11, 1'b1, o);
        e = sb.pop_front();
        checks++; if (o.any_w !== 1'b1 || o.any_r !== e.rd) begin failures++; $display("FAIL store_type got=r%0d w%0d exp=r0 w1", o.any_r, o.any_w); end
        checks++; if (o.addr !== e.addr || o.wdata !== e.wdata) begin failures++; $display("FAIL store_addr_data got=%h/%h exp=%h/%h", o.addr, o.wdata, e.addr, e.wdata); end
        checks++; if (o.valid_cycles != 6 || !o.stable) begin failures++; $display("FAIL store_hold got=%0d cycles stable=%0d exp=6 stable=1", o.valid_cycles, o.stable); end
        checks++; if (o.done_at != 8 || o.st_done !== LSU_DONE) begin failures++; $display("FAIL store_done got=%0d@%0d exp=%0d@8", o.st_done, o.done_at, LSU_DONE); end
        checks++; if (o.out_done !== model_out) begin failures++; $display("FAIL store_out got=%h exp=%h", o.out_done, model_out); end
        checks++; if (o.st_idle !== LSU_IDLE) begin failures++; $display("FAIL store_idle got=%0d exp=%0d", o.st_idle, LSU_IDLE); end
    endtask

    task automatic test_both_enables();
        obs_t o;
        exp_t e;
        sb.push_back('{rd: 1'b1, addr: 8'h03, wdata: 8'h00});
        do_txn(1'b1, 1'b1, 8'h03, 8'h55, 2, 8'h3C, 1'b0, o);
        model_out = 8'h3C;
        e = sb.pop_front();
        checks++; if (o.any_r !== e.rd || o.any_w !== 1'b0) begin failures++; $display("FAIL both_type got=r%0d w%0d exp=r1 w0", o.any_r, o.any_w); end
        checks++; if (o.addr !== e.addr) begin failures++; $display("FAIL both_addr got=%h exp=%h", o.addr, e.addr); end
        checks++; if (o.done_at != 5 || o.valid_cycles != 3) begin failures++; $display("FAIL both_latency got=%0d/%0d exp=5/3", o.done_at, o.valid_cycles); end
        checks++; if (o.out_done !== model_out) begin failures++; $display("FAIL both_out got=%h exp=%h", o.out_done, model_out); end
    endtask

    task automatic test_enable_low();
        @(negedge clk);
        enable = 1'b0; core_state = REQUEST; rd_en = 1'b1; rs = 8'h09;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (lsu_state !== LSU_IDLE || mem_read_valid !== 1'b0 || mem_write_valid !== 1'b0) begin failures++; $display("FAIL enable_low_%0d got=st%0d rv%b wv%b exp=st0 rv0 wv0", i, lsu_state, mem_read_valid, mem_write_valid); end
        end
        enable = 1'b1; core_state = IDLE; rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] tbl_addr [3] = '{8'hFF, 8'h00, 8'h81};
        logic [7:0] tbl_data [3] = '{8'h5A, 8'hC3, 8'h00};
        int         tbl_dly  [3] = '{1, 0, 3};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{rd: 1'b1, addr: tbl_addr[i], wdata: 8'h00});
            do_txn(1'b1, 1'b0, tbl_addr[i], 8'h00, tbl_dly[i], tbl_data[i], 1'b0, o);
            model_out = tbl_data[i];
            e = sb.pop_front();
            checks++; if (o.addr !== e.addr || !o.stable) begin failures++; $display("FAIL b2b_addr_%0d got=%h exp=%h", i, o.addr, e.addr); end
            checks++; if (o.out_done !== model_out) begin failures++; $display("FAIL b2b_out_%0d got=%h exp=%h", i, o.out_done, model_out); end
            checks++; if (o.done_at != 3 + tbl_dly[i]) begin failures++; $display("FAIL b2b_latency_%0d got=%0d exp=%0d", i, o.done_at, 3 + tbl_dly[i]); end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        exp_t e;
        sb.push_back('{rd: 1'b1, addr: 8'h55, wdata: 8'h00});
        do_txn(1'b1, 1'b0, 8'h55, 8'h00, 1000, 8'hEE, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.addr !== e.addr) begin failures++; $display("FAIL to_addr got=%h exp=%h", o.addr, e.addr); end
        checks++; if (o.valid_cycles != 4 || o.done_at != 6 || o.st_done !== LSU_DONE) begin failures++; $display("FAIL to_abort got=%0d cycles st%0d@%0d exp=4 cycles st3@6", o.valid_cycles, o.st_done, o.done_at); end
        checks++; if (o.err_done !== 1'b1) begin failures++; $display("FAIL to_error got=%b exp=1", o.err_done); end
        checks++; if (o.out_done !== model_out) begin failures++; $display("FAIL to_out got=%h exp=%h", o.out_done, model_out); end
        sb.push_back('{rd: 1'b1, addr: 8'h56, wdata: 8'h00});
        do_txn(1'b1, 1'b0, 8'h56, 8'h00, 3, 8'h99, 1'b0, o);
        model_out = 8'h99;
        e = sb.pop_front();
        checks++; if (o.err_req !== 1'b0) begin failures++; $display("FAIL to_error_clear got=%b exp=0", o.err_req); end
        checks++; if (o.err_done !== 1'b0 || o.done_at != 6) begin failures++; $display("FAIL to_ready_wins got=err%b@%0d exp=err0@6", o.err_done, o.done_at); end
        checks++; if (o.out_done !== model_out || o.addr !== e.addr) begin failures++; $display("FAIL to_ready_out got=%h/%h exp=%h/%h", o.out_done, o.addr, model_out, e.addr); end
    endtask
`endif

    task automatic test_async_reset();
        @(negedge clk);
        enable = 1'b1; core_state = REQUEST; rd_en = 1'b1; rs = 8'h21;
        @(negedge clk);
        core_state = WAIT;
        @(negedge clk);
        checks++; if (lsu_state !== LSU_WAITING || mem_read_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=st%0d rv%b exp=st2 rv1", lsu_state, mem_read_valid); end
        #2 reset = 1'b1;
        #1;
        model_out = 8'h00;
        checks++; if (lsu_state !== LSU_IDLE) begin failures++; $display("FAIL arst_state got=%0d exp=%0d", lsu_state, LSU_IDLE); end
        checks++; if ({mem_read_valid, mem_write_valid} !== 2'b00 || mem_read_address !== 8'h00) begin failures++; $display("FAIL arst_valid got=%b addr=%h exp=00 addr=00", {mem_read_valid, mem_write_valid}, mem_read_address); end
        checks++; if (lsu_out !== model_out) begin failures++; $display("FAIL arst_out got=%h exp=%h", lsu_out, model_out); end
        @(negedge clk);
        reset = 1'b0; core_state = IDLE; rd_en = 1'b0;
        @(negedge clk);
        checks++; if (lsu_state !== LSU_IDLE || mem_read_valid !== 1'b0) begin failures++; $display("FAIL arst_after got=st%0d rv%b exp=st0 rv0", lsu_state, mem_read_valid); end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; core_state = IDLE;
        rd_en = 1'b0; wr_en = 1'b0; rs = '0; rt = '0;
        mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
        test_reset();
        test_load_immediate();
        test_store_delayed();
        test_both_enables();
        test_enable_low();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
